// File: rtl/coin_pkg.sv
// Shared types for the coin payout path: coin codes, coin values and FSM states.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_1    = 2'd1,
    COIN_3    = 2'd2,
    COIN_5    = 2'd3
  } coin_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_GAP,
    S_DONE,
    S_STUCK
  } state_t;

  localparam logic [2:0] VAL_1 = 3'd1;
  localparam logic [2:0] VAL_3 = 3'd3;
  localparam logic [2:0] VAL_5 = 3'd5;

  function automatic logic [2:0] coin_val(input coin_t c);
    logic [2:0] v;
    v = 3'd0;
    case (c)
      COIN_1:  v = VAL_1;
      COIN_3:  v = VAL_3;
      COIN_5:  v = VAL_5;
      default: v = 3'd0;
    endcase
    return v;
  endfunction

  // Greedy pick; empty[2:0] = {5-unit, 3-unit, 1-unit} hopper empty.
  function automatic coin_t coin_pick(
    input logic       ge5,
    input logic       ge3,
    input logic       ge1,
    input logic [2:0] empty
  );
    coin_t c;
    c = COIN_NONE;
    if (ge5 && !empty[2])
      c = COIN_5;
    else if (ge3 && !empty[1])
      c = COIN_3;
    else if (ge1 && !empty[0])
      c = COIN_1;
    return c;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter; o_tc flags the last cycle of a loaded interval.
module pulse_timer #(
  parameter int W = 2
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/coin_dispenser.sv
// Greedy 5/3/1 coin payout engine with pulsed CoinValue/CoinEject output.
// Define COIN_DISPENSE_COUNT_EN to enable the saturating DispensedTotal counter.
module coin_dispenser
  import coin_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int AMT_W        = 6
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             PayoutReq,
  input  logic [AMT_W-1:0] PayoutAmount,
  input  logic [2:0]       HopperEmpty,
  output logic [1:0]       CoinValue,
  output logic             CoinEject,
  output logic             busy,
  output logic             done,
  output logic             stuck,
  output logic [AMT_W-1:0] Remaining,
  output logic [7:0]       DispensedTotal
);

  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);

  state_t           r_state;
  coin_t            r_coin;
  logic             r_eject;
  logic             r_busy;
  logic             r_done;
  logic             r_stuck;
  logic [AMT_W-1:0] r_rem;

  coin_t            w_pick;
  logic             w_found;
  logic             w_tc;
  logic             w_load;
  logic [TW-1:0]    w_load_val;
  logic [AMT_W-1:0] w_sub;

  assign w_pick = coin_pick(r_rem >= AMT_W'(5),
                            r_rem >= AMT_W'(3),
                            r_rem >= AMT_W'(1),
                            HopperEmpty);
  assign w_found = (w_pick != COIN_NONE);
  assign w_sub   = r_rem - AMT_W'(coin_val(r_coin));

  // One timer serves both intervals: pulse loaded from SELECT, gap from EJECT.
  assign w_load = ((r_state == S_SELECT) && w_found) ||
                  ((r_state == S_EJECT) && w_tc);
  assign w_load_val = (r_state == S_SELECT) ? TW'(PULSE_CYCLES - 1)
                                            : TW'(GAP_CYCLES - 1);

  pulse_timer #(
    .W(TW)
  ) u_timer (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .o_tc      (w_tc)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_coin  <= COIN_NONE;
      r_eject <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_stuck <= 1'b0;
      r_rem   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (PayoutReq) begin
            r_rem  <= PayoutAmount;
            r_busy <= 1'b1;
            if (PayoutAmount == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_SELECT;
            end
          end
        end
        S_SELECT: begin
          if (w_found) begin
            r_coin  <= w_pick;
            r_eject <= 1'b1;
            r_state <= S_EJECT;
          end else begin
            r_stuck <= 1'b1;
            r_state <= S_STUCK;
          end
        end
        S_EJECT: begin
          if (w_tc) begin
            r_rem   <= w_sub;
            r_eject <= 1'b0;
            r_coin  <= COIN_NONE;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_tc) begin
            if (r_rem == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_SELECT;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_STUCK: begin
          if (w_found) begin
            r_stuck <= 1'b0;
            r_state <= S_SELECT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign CoinValue = r_coin;
  assign CoinEject = r_eject;
  assign busy      = r_busy;
  assign done      = r_done;
  assign stuck     = r_stuck;
  assign Remaining = r_rem;

`ifdef COIN_DISPENSE_COUNT_EN
  logic [7:0] r_total;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)
      r_total <= '0;
    else if ((r_state == S_EJECT) && w_tc && (r_total != 8'hFF))
      r_total <= r_total + 8'd1;
  end

  assign DispensedTotal = r_total;
`else
  assign DispensedTotal = '0;
`endif

endmodule

// File: doc/coin_dispenser.md
# coin_dispenser

Change/refund payout engine for the arcade credit path: accepts a refund amount in credit units and ejects coins greedily (5, then 3, then 1 unit) through a pulsed CoinValue/CoinEject interface. It is the transmit-side counterpart of the coin acceptor. Its output encoding and pulse shape drive the acceptor's CoinValue/CoinInserted inputs directly, so the two blocks run in loopback on the bench and on the board.

## Interface
- PULSE_CYCLES, 4, cycles CoinEject is held high per coin (≥1)
- GAP_CYCLES, 4, low cycles after each pulse (≥1), guarantees a clean rising edge for the next coin
- AMT_W, 6, width of payout amount / remaining counter

Ports:
- CLOCK_50  in  1  clock
- reset  in  1  asynchronous, active-high
- PayoutReq  in  1  start request, sampled only in IDLE
- PayoutAmount  in  AMT_W  amount in credit units, latched with PayoutReq
- HopperEmpty  in  3  bit0 = 1-unit, bit1 = 3-unit, bit2 = 5-unit hopper empty
- CoinValue  out  2  coin code: 0 none, 1 = 1 unit, 2 = 3 units, 3 = 5 units
- CoinEject  out  1  eject strobe
- busy  out  1  high from the cycle after an accepted request until DONE exits
- done  out  1  single-cycle completion pulse
- stuck  out  1  no eligible coin available, level
- Remaining  out  AMT_W  units still owed
- DispensedTotal  out  8  coins ejected since reset (see Configuration)

Reset, asynchronous, active-high; clock CLOCK_50. All outputs are 0 in reset. FSM enters IDLE.

## Operation
- States: IDLE, SELECT, EJECT, GAP, DONE, STUCK. All outputs are registered.
- IDLE: busy=0. On PayoutReq=1: Remaining←PayoutAmount. If amount is 0, go to DONE. Otherwise go to SELECT.
- SELECT (1 cycle): pick the largest coin with value ≤ Remaining and its HopperEmpty bit clear. If a coin is found: latch its code into CoinValue, load the timer with PULSE_CYCLES, and go to EJECT. If none: go to STUCK.
- EJECT: CoinEject=1 and CoinValue stable for exactly PULSE_CYCLES cycles. On the last cycle, Remaining←Remaining−value, then go to GAP.
- GAP: CoinEject=0, CoinValue=0 for GAP_CYCLES cycles. Then go to DONE if Remaining==0, otherwise to SELECT.
- DONE: done=1 for one cycle, busy=1, then go to IDLE.
- STUCK: stuck=1, busy=1, Remaining holds. The coin choice is re-evaluated every cycle. When an eligible coin appears, go to SELECT. This does not backtrack: greedy choices already made stand.
- PayoutReq outside IDLE is ignored; no queueing.
- HopperEmpty changes during EJECT/GAP do not affect the coin in flight.
- Subtraction never underflows, because a coin is only selected when value ≤ Remaining.

## Timing
- Request accepted in cycle 0; SELECT occupies cycle 1.
- Each coin costs 1 + PULSE_CYCLES + GAP_CYCLES cycles.
- With no stall, done is high in cycle n·(1+PULSE_CYCLES+GAP_CYCLES)+1 for n coins, which is 9n+1 with the defaults.
- Zero amount: done is high in cycle 1.
- Reset mid-operation takes effect immediately:
  - CoinEject drops in the same cycle (asynchronous).
  - The partially paid amount is lost and Remaining=0.
  - No done pulse is produced.

## Configuration
- COIN_DISPENSE_COUNT_EN defined: DispensedTotal increments by 1 on the last EJECT cycle of each coin. It saturates at 255 and clears only on reset.
- Not defined: DispensedTotal is tied to 0 and the counter logic is absent.

## Structure
- Shared package coin_pkg holds:
  - coin_t enum: COIN_NONE=0, COIN_1=1, COIN_3=2, COIN_5=3
  - the coin value function/constants (1, 3, 5)
  - the FSM state enum
- One sub-module, pulse_timer: a loadable down-counter with a terminal-count flag, used for both the EJECT and GAP intervals.

## Test plan
- Amount 8, hoppers full, defaults → CoinValue 3 then 2, each with CoinEject high 4 cycles. Remaining 8→3→0; done in cycle 19.
- Amount 0 → done in cycle 1; CoinEject never asserts; busy high only in cycle 1.
- Amount 7, HopperEmpty=3'b100 → coin codes 2, 2, 1; done in cycle 28.
- Amount 2, HopperEmpty=3'b001 → stuck=1 from cycle 2 with Remaining=2. Clear bit0 at cycle 10 → two code-1 pulses, then done, and stuck drops.
- Reset asserted mid-EJECT of an 8 request → CoinEject=0 the same cycle, busy=0, Remaining=0. A new request for 1 then completes in cycle 10.
- PayoutReq pulsed while busy is ignored. With COIN_DISPENSE_COUNT_EN, 300 single-unit payouts give DispensedTotal=255.
